sync_fifo_thresh: RTL and testbench
===================================

# sync_fifo_thresh

Single-clock, parametrised FIFO for buffering within one clock domain. It is the successor to the dual-clock FIFO: width, depth and flag thresholds are all parameters. It adds an occupancy count, almost-full/almost-empty flags, overflow/underflow error pulses and a synchronous flush. It sits between a producer and a consumer that share one clock and need back-pressure before the hard FULL limit.

## Interface
- `width`, 8, data word width in bits
- `p_width`, 4, pointer width including the wrap bit; DEPTH = 2**(p_width-1) = 8 by default
- `AF_LEVEL`, 6, ALMOST_FULL asserts when COUNT >= AF_LEVEL
- `AE_LEVEL`, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL
- Parameter constraint: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH
- `CLK`  in  1  single clock; all logic on the rising edge
- `RST`  in  1  reset, asynchronous, active-low
- `CLR`  in  1  synchronous flush
- `W_INC`  in  1  write request
- `R_INC`  in  1  read request
- `WR_DATA`  in  width  write data
- `RD_DATA`  out  width  read data
- `FULL`  out  1  COUNT == DEPTH
- `EMPTY`  out  1  COUNT == 0
- `ALMOST_FULL`  out  1  COUNT >= AF_LEVEL
- `ALMOST_EMPTY`  out  1  COUNT <= AE_LEVEL
- `COUNT`  out  p_width  occupancy, 0..DEPTH
- `OVERFLOW`  out  1  one-cycle pulse: a write was rejected
- `UNDERFLOW`  out  1  one-cycle pulse: a read was rejected

## Operation
- Storage is a DEPTH x width register array.
- There is a write pointer and a read pointer, each p_width bits. The low p_width-1 bits address the array. The MSB is the wrap bit. Pointers wrap from DEPTH*2-1 to 0.
- Write acceptance: `wr_ok = W_INC & ~FULL & ~CLR`. On wr_ok, store WR_DATA at wptr and increment wptr.
- Read acceptance: `rd_ok = R_INC & ~EMPTY & ~CLR`. On rd_ok, increment rptr.
- COUNT update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged on both or neither.
  - COUNT is registered; it never exceeds DEPTH and never underflows.
- Simultaneous read and write:
  - When FULL: only the read is accepted. The write is rejected and OVERFLOW pulses.
  - When EMPTY: only the write is accepted. The read is rejected and UNDERFLOW pulses.
  - Otherwise: both are accepted and COUNT is unchanged.
- Flags FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY are decoded combinationally from the registered COUNT.
- OVERFLOW is registered: set for one cycle after an edge where `W_INC & FULL & ~CLR`.
- UNDERFLOW is registered: set for one cycle after an edge where `R_INC & EMPTY & ~CLR`.
- CLR has priority over W_INC and R_INC:
  - Sets both pointers and COUNT to 0.
  - Array contents are not cleared.
  - RD_DATA holds its value.
  - No error pulses are raised.
- Reset values, applied immediately when RST goes low:
  - wptr = rptr = 0, COUNT = 0.
  - EMPTY = 1, FULL = 0.
  - ALMOST_EMPTY = 1, ALMOST_FULL = 0 (AF_LEVEL >= 1).
  - OVERFLOW = 0, UNDERFLOW = 0.
  - RD_DATA = 0.
- Reset mid-operation discards all contents. The first write after RST deasserts lands at address 0.

## Timing
- Write latency:
  - Word accepted at edge k.
  - COUNT and flags reflect it after edge k.
  - The word is readable from edge k+1 onward.
- Read latency (standard mode): with R_INC accepted at edge k, RD_DATA presents the word after edge k. RD_DATA holds between reads.
- Back-to-back writes and reads are sustained at one word per clock.
- Producers must sample FULL and ALMOST_FULL before asserting W_INC. A rejected write is lost and reported only via OVERFLOW.

## Configuration
- `FIFO_FWFT_EN` defined (first-word-fall-through mode):
  - RD_DATA continuously shows mem[rptr] while EMPTY = 0.
  - R_INC pops the head, and RD_DATA shows the next word after that edge.
  - While EMPTY = 1, RD_DATA holds its last value.
- `FIFO_FWFT_EN` not defined (standard mode): registered read data with the 1-cycle latency described under Timing.
- All flags, counts and error pulses are identical in both modes.

## Test plan
All scenarios use the default parameters (DEPTH 8, AF_LEVEL 6, AE_LEVEL 2).

- Reset, then write AA, BC, 6F, FF.
  - COUNT goes 1, 2, 3, 4; EMPTY = 0 after the first write; ALMOST_EMPTY drops after the 3rd write.
  - Four reads return AA, BC, 6F, FF in order; EMPTY = 1 afterwards.
- Fill with A5, C3, 32, FF, 92, D7, 55, 4F.
  - ALMOST_FULL = 1 at COUNT 6; FULL = 1 at COUNT 8.
  - A 9th write of 11 gives OVERFLOW pulsing for exactly 1 cycle, COUNT stays 8, and 11 is never read back.
- On an empty FIFO, assert R_INC alone: UNDERFLOW pulses 1 cycle, COUNT stays 0, RD_DATA unchanged.
  - Then assert W_INC and R_INC together with data 5A: only the write is accepted and COUNT = 1.
- With COUNT = 8, assert W_INC (data 77) and R_INC together.
  - Read returns A5; the write is rejected with OVERFLOW = 1 and COUNT = 7.
  - With COUNT = 4, simultaneous read and write leaves COUNT at 4.
- Wrap-around: run 20 write/read pairs of an incrementing pattern 00..13. Data is returned in order across two pointer wraps with no false FULL or EMPTY.
- Flush and reset:
  - With COUNT = 5, assert CLR together with W_INC. COUNT = 0, EMPTY = 1, no OVERFLOW.
  - With COUNT = 3, pulse RST low mid-cycle. All outputs take their reset values asynchronously.

Source files
------------

// File: rtl/sync_fifo_thresh.sv
// sync_fifo_thresh
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty
// thresholds, one-cycle overflow/underflow error pulses and a synchronous flush.
//
// Optional feature macro: FIFO_FWFT_EN
//    defined     -> first-word-fall-through: RD_DATA shows the head word while
//                   the FIFO is not empty and holds its last value while empty.
//    not defined -> standard mode: RD_DATA is registered and updated on the
//                   edge that accepts a read.
//
// Parameters:
//    width     data word width
//    p_width   pointer width including wrap bit, DEPTH = 2**(p_width-1)
//    AF_LEVEL  ALMOST_FULL when COUNT >= AF_LEVEL
//    AE_LEVEL  ALMOST_EMPTY when COUNT <= AE_LEVEL
//
// Ports:
//    CLK           clock, rising edge
//    RST           asynchronous active-low reset
//    CLR           synchronous flush (priority over W_INC / R_INC)
//    W_INC         write request
//    R_INC         read request
//    WR_DATA       write data
//    RD_DATA       read data
//    FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY   flags decoded from COUNT
//    COUNT         occupancy 0..DEPTH
//    OVERFLOW      one-cycle pulse after a rejected write
//    UNDERFLOW     one-cycle pulse after a rejected read

module sync_fifo_thresh #(
   parameter int width    = 8,
   parameter int p_width  = 4,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               CLR,
   input  logic               W_INC,
   input  logic               R_INC,
   input  logic [width-1:0]   WR_DATA,
   output logic [width-1:0]   RD_DATA,
   output logic               FULL,
   output logic               EMPTY,
   output logic               ALMOST_FULL,
   output logic               ALMOST_EMPTY,
   output logic [p_width-1:0] COUNT,
   output logic               OVERFLOW,
   output logic               UNDERFLOW
);

   localparam int DEPTH = 2 ** (p_width - 1);
   localparam int AW    = p_width - 1;

   localparam logic [p_width-1:0] DEPTH_C = p_width'(DEPTH);
   localparam logic [p_width-1:0] AF_C    = p_width'(AF_LEVEL);
   localparam logic [p_width-1:0] AE_C    = p_width'(AE_LEVEL);
   localparam logic [p_width-1:0] ONE_C   = p_width'(1);

   logic [width-1:0]   mem [DEPTH];
   logic [p_width-1:0] wptr;
   logic [p_width-1:0] rptr;
   logic               wr_ok;
   logic               rd_ok;

   // Flags come straight from the registered occupancy so they never glitch
   // relative to COUNT.
   assign FULL         = (COUNT == DEPTH_C);
   assign EMPTY        = (COUNT == '0);
   assign ALMOST_FULL  = (COUNT >= AF_C);
   assign ALMOST_EMPTY = (COUNT <= AE_C);

   // Flush blocks both sides so a flush cycle never moves data or raises errors.
   assign wr_ok = W_INC & ~FULL & ~CLR;
   assign rd_ok = R_INC & ~EMPTY & ~CLR;

   // Storage array; left unreset since pointers and COUNT define what is valid.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem[wptr[AW-1:0]] <= WR_DATA;
      end
   end

   // Pointers carry an extra wrap bit and simply roll over at 2*DEPTH.
   // COUNT tracks occupancy directly rather than being derived from pointers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wptr  <= '0;
         rptr  <= '0;
         COUNT <= '0;
      end else if (CLR) begin
         wptr  <= '0;
         rptr  <= '0;
         COUNT <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + ONE_C;
         end
         if (rd_ok) begin
            rptr <= rptr + ONE_C;
         end
         unique case ({wr_ok, rd_ok})
            2'b10:   COUNT <= COUNT + ONE_C;
            2'b01:   COUNT <= COUNT - ONE_C;
            default: COUNT <= COUNT;
         endcase
      end
   end

   // Error pulses reflect rejected requests on the previous edge; a flush
   // cycle suppresses them.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         OVERFLOW  <= W_INC & FULL & ~CLR;
         UNDERFLOW <= R_INC & EMPTY & ~CLR;
      end
   end

`ifdef FIFO_FWFT_EN
   logic [width-1:0] hold_data;

   // hold_data tracks whatever was last on the output while non-empty, so the
   // output keeps its last value once the FIFO drains or is flushed.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hold_data <= '0;
      end else if (!EMPTY) begin
         hold_data <= mem[rptr[AW-1:0]];
      end
   end

   assign RD_DATA = EMPTY ? hold_data : mem[rptr[AW-1:0]];
`else
   // Registered read port: the popped word appears after the accepting edge
   // and holds until the next accepted read.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         RD_DATA <= '0;
      end else if (rd_ok) begin
         RD_DATA <= mem[rptr[AW-1:0]];
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// tb_sync_fifo_thresh
// Self-checking bench for sync_fifo_thresh in standard (registered read) mode
// with default parameters. A queue-based reference model predicts occupancy,
// flags, error pulses and read data.

module tb_sync_fifo_thresh;

   logic       CLK;
   logic       RST;
   logic       CLR;
   logic       W_INC;
   logic       R_INC;
   logic [7:0] WR_DATA;
   logic [7:0] RD_DATA;
   logic       FULL;
   logic       EMPTY;
   logic       ALMOST_FULL;
   logic       ALMOST_EMPTY;
   logic [3:0] COUNT;
   logic       OVERFLOW;
   logic       UNDERFLOW;

   int checks;
   int failures;

   // Reference model state
   logic [7:0] q [$];
   logic [7:0] exp_rd;
   logic       exp_ovf;
   logic       exp_unf;

   sync_fifo_thresh dut (
      .CLK          (CLK),
      .RST          (RST),
      .CLR          (CLR),
      .W_INC        (W_INC),
      .R_INC        (R_INC),
      .WR_DATA      (WR_DATA),
      .RD_DATA      (RD_DATA),
      .FULL         (FULL),
      .EMPTY        (EMPTY),
      .ALMOST_FULL  (ALMOST_FULL),
      .ALMOST_EMPTY (ALMOST_EMPTY),
      .COUNT        (COUNT),
      .OVERFLOW     (OVERFLOW),
      .UNDERFLOW    (UNDERFLOW)
   );

   // 10 time-unit clock, rising edges at 5, 15, 25, ...
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive one cycle of requests, advance the reference model across the
   // edge, and return 1 time unit after the edge with requests idle.
   task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
      bit full_b;
      bit empty_b;
      W_INC   = w;
      R_INC   = r;
      WR_DATA = d;
      CLR     = c;
      @(posedge CLK);
      full_b  = (q.size() == 8);
      empty_b = (q.size() == 0);
      if (c) begin
         q.delete();
         exp_ovf = 1'b0;
         exp_unf = 1'b0;
      end else begin
         exp_ovf = w && full_b;
         exp_unf = r && empty_b;
         if (r && !empty_b) exp_rd = q.pop_front();
         if (w && !full_b) q.push_back(d);
      end
      #1;
      W_INC = 1'b0;
      R_INC = 1'b0;
      CLR   = 1'b0;
   endtask

   task automatic model_reset();
      q.delete();
      exp_rd  = 8'h00;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      CLR = 1'b0; W_INC = 1'b0; R_INC = 1'b0; WR_DATA = 8'h00;
      model_reset();
      #12;
      checks++; if (COUNT !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", COUNT); end
      checks++; if (EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", EMPTY); end
      checks++; if (FULL !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", FULL); end
      checks++; if (ALMOST_EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL reset_ae got=%b exp=1", ALMOST_EMPTY); end
      checks++; if (ALMOST_FULL !== 1'b0) begin failures++; $display("[TB] FAIL reset_af got=%b exp=0", ALMOST_FULL); end
      checks++; if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin failures++; $display("[TB] FAIL reset_err got=%b%b exp=00", OVERFLOW, UNDERFLOW); end
      checks++; if (RD_DATA !== 8'h00) begin failures++; $display("[TB] FAIL reset_rd got=%h exp=00", RD_DATA); end
      RST = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_basic_order();
      logic [7:0] pat [4] = '{8'hAA, 8'hBC, 8'h6F, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, pat[i], 1'b0);
         checks++; if (COUNT !== 4'(i + 1)) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=%0d", COUNT, i + 1); end
         checks++; if (EMPTY !== 1'b0) begin failures++; $display("[TB] FAIL basic_empty got=%b exp=0", EMPTY); end
         checks++; if (ALMOST_EMPTY !== (i < 2)) begin failures++; $display("[TB] FAIL basic_ae got=%b exp=%b", ALMOST_EMPTY, (i < 2)); end
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 8'h00, 1'b0);
         checks++; if (RD_DATA !== pat[i]) begin failures++; $display("[TB] FAIL basic_rd got=%h exp=%h", RD_DATA, pat[i]); end
      end
      checks++; if (EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL basic_empty_end got=%b exp=1", EMPTY); end
   endtask

   task automatic test_fill_overflow();
      logic [7:0] pat [8] = '{8'hA5, 8'hC3, 8'h32, 8'hFF, 8'h92, 8'hD7, 8'h55, 8'h4F};
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, pat[i], 1'b0);
         checks++; if (ALMOST_FULL !== (i + 1 >= 6)) begin failures++; $display("[TB] FAIL fill_af count=%0d got=%b exp=%b", i + 1, ALMOST_FULL, (i + 1 >= 6)); end
         checks++; if (FULL !== (i == 7)) begin failures++; $display("[TB] FAIL fill_full count=%0d got=%b exp=%b", i + 1, FULL, (i == 7)); end
      end
      step(1'b1, 1'b0, 8'h11, 1'b0);
      checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("[TB] FAIL ovf_pulse got=%b exp=1", OVERFLOW); end
      checks++; if (COUNT !== 4'd8) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=8", COUNT); end
      step(1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("[TB] FAIL ovf_one_cycle got=%b exp=0", OVERFLOW); end
   endtask

   task automatic test_full_simultaneous();
      // FIFO still holds A5..4F from the fill test
      step(1'b1, 1'b1, 8'h77, 1'b0);
      checks++; if (RD_DATA !== 8'hA5) begin failures++; $display("[TB] FAIL fullsim_rd got=%h exp=a5", RD_DATA); end
      checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("[TB] FAIL fullsim_ovf got=%b exp=1", OVERFLOW); end
      checks++; if (COUNT !== 4'd7) begin failures++; $display("[TB] FAIL fullsim_count got=%0d exp=7", COUNT); end
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, 8'h00, 1'b0);
         checks++; if (RD_DATA !== exp_rd || RD_DATA === 8'h11 || RD_DATA === 8'h77) begin failures++; $display("[TB] FAIL drain_rd got=%h exp=%h", RD_DATA, exp_rd); end
      end
      checks++; if (EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL drain_empty got=%b exp=1", EMPTY); end
   endtask

   task automatic test_underflow();
      logic [7:0] prev;
      prev = exp_rd;
      step(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if (UNDERFLOW !== 1'b1) begin failures++; $display("[TB] FAIL unf_pulse got=%b exp=1", UNDERFLOW); end
      checks++; if (COUNT !== 4'd0) begin failures++; $display("[TB] FAIL unf_count got=%0d exp=0", COUNT); end
      checks++; if (RD_DATA !== prev) begin failures++; $display("[TB] FAIL unf_rd_hold got=%h exp=%h", RD_DATA, prev); end
      step(1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (UNDERFLOW !== 1'b0) begin failures++; $display("[TB] FAIL unf_one_cycle got=%b exp=0", UNDERFLOW); end
      step(1'b1, 1'b1, 8'h5A, 1'b0);
      checks++; if (COUNT !== 4'd1) begin failures++; $display("[TB] FAIL emptysim_count got=%0d exp=1", COUNT); end
      checks++; if (UNDERFLOW !== 1'b1) begin failures++; $display("[TB] FAIL emptysim_unf got=%b exp=1", UNDERFLOW); end
      checks++; if (RD_DATA !== prev) begin failures++; $display("[TB] FAIL emptysim_rd got=%h exp=%h", RD_DATA, prev); end
   endtask

   task automatic test_mid_simultaneous();
      // Holds 5A; bring occupancy to 4, then read+write together
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
      step(1'b1, 1'b1, 8'h99, 1'b0);
      checks++; if (COUNT !== 4'd4) begin failures++; $display("[TB] FAIL midsim_count got=%0d exp=4", COUNT); end
      checks++; if (RD_DATA !== 8'h5A) begin failures++; $display("[TB] FAIL midsim_rd got=%h exp=5a", RD_DATA); end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 8'h00, 1'b0);
         checks++; if (RD_DATA !== exp_rd) begin failures++; $display("[TB] FAIL midsim_drain got=%h exp=%h", RD_DATA, exp_rd); end
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 8'(i), 1'b0);
         checks++; if (FULL !== 1'b0 || EMPTY !== 1'b0) begin failures++; $display("[TB] FAIL wrap_flags_w i=%0d got full=%b empty=%b exp full=0 empty=0", i, FULL, EMPTY); end
         step(1'b0, 1'b1, 8'h00, 1'b0);
         checks++; if (RD_DATA !== 8'(i)) begin failures++; $display("[TB] FAIL wrap_rd i=%0d got=%h exp=%h", i, RD_DATA, 8'(i)); end
         checks++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin failures++; $display("[TB] FAIL wrap_flags_r i=%0d got full=%b empty=%b exp full=0 empty=1", i, FULL, EMPTY); end
      end
   endtask

   task automatic test_flush();
      logic [7:0] prev;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
      prev = exp_rd;
      step(1'b1, 1'b0, 8'hEE, 1'b1);
      checks++; if (COUNT !== 4'd0) begin failures++; $display("[TB] FAIL flush_count got=%0d exp=0", COUNT); end
      checks++; if (EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty got=%b exp=1", EMPTY); end
      checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("[TB] FAIL flush_ovf got=%b exp=0", OVERFLOW); end
      checks++; if (RD_DATA !== prev) begin failures++; $display("[TB] FAIL flush_rd_hold got=%h exp=%h", RD_DATA, prev); end
      step(1'b1, 1'b0, 8'h3C, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if (RD_DATA !== 8'h3C) begin failures++; $display("[TB] FAIL flush_after_rd got=%h exp=3c", RD_DATA); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hB0 + i), 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'hB3, 1'b0);
      // Now at edge+1 with three words held; drop reset mid-cycle
      #2;
      RST = 1'b0;
      model_reset();
      #1;
      checks++; if (COUNT !== 4'd0) begin failures++; $display("[TB] FAIL areset_count got=%0d exp=0", COUNT); end
      checks++; if ({EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL} !== 4'b1010) begin failures++; $display("[TB] FAIL areset_flags got=%b%b%b%b exp=1010", EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL); end
      checks++; if (RD_DATA !== 8'h00) begin failures++; $display("[TB] FAIL areset_rd got=%h exp=00", RD_DATA); end
      checks++; if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin failures++; $display("[TB] FAIL areset_err got=%b%b exp=00", OVERFLOW, UNDERFLOW); end
      #3;
      RST = 1'b1;
      @(posedge CLK); #1;
      step(1'b1, 1'b0, 8'hD1, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if (RD_DATA !== 8'hD1 || EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL areset_first got rd=%h empty=%b exp rd=d1 empty=1", RD_DATA, EMPTY); end
   endtask

   task automatic test_random();
      logic w, r, c;
      logic [7:0] d;
      int sz;
      for (int n = 0; n < 400; n++) begin
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 45);
         c = ($urandom_range(0, 63) == 0);
         d = 8'($urandom);
         step(w, r, d, c);
         sz = q.size();
         checks++;
         if (COUNT !== 4'(sz) || FULL !== (sz == 8) || EMPTY !== (sz == 0) ||
             ALMOST_FULL !== (sz >= 6) || ALMOST_EMPTY !== (sz <= 2) ||
             OVERFLOW !== exp_ovf || UNDERFLOW !== exp_unf || RD_DATA !== exp_rd) begin
            failures++;
            $display("[TB] FAIL random n=%0d got cnt=%0d f=%b e=%b af=%b ae=%b ovf=%b unf=%b rd=%h exp cnt=%0d ovf=%b unf=%b rd=%h",
                     n, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW, RD_DATA,
                     sz, exp_ovf, exp_unf, exp_rd);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_order();
      test_fill_overflow();
      test_full_simultaneous();
      test_underflow();
      test_mid_simultaneous();
      test_wrap();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
